// File: rtl/bg_afe_model.sv
// Behavioural stand-in for the bandgap analog front end: follows the SAR controller's
// small/big/compare phase sequence, returns CMPO and flags out-of-order phases.
`timescale 1ns/1ps
// state  | meaning
// IDLE   | waiting for a SMALL phase
// SMALL  | small-diode sample, codeS latched
// HOLD1  | cap-1 holding, waiting for BIG phase
// BIG    | big-diode sample, codeB latched
// HOLD2  | cap-2 holding, waiting for COMPARE phase
// SETTLE | comparator settling down-count
// DONE   | CMPO updated, waiting for COMPARE to drop
module bg_afe_model #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CODE_W        = 8,
  parameter int unsigned OFS_W         = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pwrup,
  input  logic [CODE_W-1:0] idacCoarse,
  input  logic [7:0]        diodeSelect,
  input  logic              resPtatEnable_n,
  input  logic [1:0]        c1,
  input  logic [1:0]        c2,
  input  logic              cmpZeroOffset,
  input  logic              cmpSwapInput,
  input  logic [CODE_W-1:0] cfgTarget,
  input  logic [OFS_W-1:0]  cfgOffset,
  output logic              CMPO,
  output logic [3:0]        cmpCount,
  output logic              phaseErr,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SMALL, ST_HOLD1, ST_BIG, ST_HOLD2, ST_SETTLE, ST_DONE
  } state_t;

  localparam int unsigned D_W      = CODE_W + 2;
  localparam logic [3:0]  CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_s_q, code_b_q;
  logic [3:0]        cnt_q;
  logic              small_p, big_p, cmp_p;
  logic              latch_s, latch_b, load_cnt, dec_cnt, do_update, set_err, set_busy, clr_busy;
  logic [D_W-1:0]    ofs_ext, diff;
  logic              raw;

  assign small_p = (diodeSelect == 8'h01) &&  resPtatEnable_n && (c1 == 2'd2);
  assign big_p   = (diodeSelect == 8'hFF) && !resPtatEnable_n && (c2 == 2'd2);
  assign cmp_p   = (c1 == 2'd1) && (c2 == 2'd1);

  // Two guard bits keep the signed difference exact across the full code and offset range.
  assign ofs_ext = cmpZeroOffset ? '0 : {{(D_W-OFS_W){cfgOffset[OFS_W-1]}}, cfgOffset};
  assign diff    = {2'b00, code_b_q} - {2'b00, cfgTarget} + ofs_ext;
  assign raw     = !diff[D_W-1] && (diff != '0);

  always_comb begin
    state_d   = state_q;
    latch_s   = 1'b0;
    latch_b   = 1'b0;
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    do_update = 1'b0;
    set_err   = 1'b0;
    set_busy  = 1'b0;
    clr_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_IDLE && (cmp_p || big_p)) begin
          set_err  = 1'b1;
          clr_busy = 1'b1;
        end else if (small_p) begin
          state_d  = ST_SMALL;
          latch_s  = 1'b1;
          set_busy = 1'b1;
        end else if (state_q == ST_DONE && !cmp_p) begin
          state_d = ST_IDLE;
        end
      end
      ST_SMALL, ST_BIG: begin
        if (cmp_p) begin
          state_d  = ST_IDLE;
          set_err  = 1'b1;
          clr_busy = 1'b1;
        end else if (state_q == ST_SMALL && c1 == 2'd0) begin
          state_d = ST_HOLD1;
        end else if (state_q == ST_BIG && c2 == 2'd0) begin
          state_d = ST_HOLD2;
        end
      end
      ST_HOLD1: begin
        if (cmp_p) begin
          state_d  = ST_IDLE;
          set_err  = 1'b1;
          clr_busy = 1'b1;
        end else if (small_p) begin
          state_d  = ST_SMALL;
          latch_s  = 1'b1;
          set_busy = 1'b1;
        end else if (big_p) begin
          state_d = ST_BIG;
          latch_b = 1'b1;
        end
      end
      ST_HOLD2: begin
        if (small_p) begin
          state_d  = ST_SMALL;
          latch_s  = 1'b1;
          set_busy = 1'b1;
        end else if (cmp_p) begin
          if (code_s_q != code_b_q) begin
            state_d  = ST_IDLE;
            set_err  = 1'b1;
            clr_busy = 1'b1;
          end else begin
            state_d  = ST_SETTLE;
            load_cnt = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_DONE;
          do_update = 1'b1;
          clr_busy  = 1'b1;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      code_s_q <= '0;
      code_b_q <= '0;
      cnt_q    <= '0;
      CMPO     <= 1'b0;
      cmpCount <= '0;
      phaseErr <= 1'b0;
      busy     <= 1'b0;
    end else if (!pwrup) begin
      // Powered down: abandon any sequence but keep the count and error history.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      CMPO    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_s) code_s_q <= idacCoarse;
      if (latch_b) code_b_q <= idacCoarse;
      if (load_cnt)     cnt_q <= CNT_LOAD;
      else if (dec_cnt) cnt_q <= cnt_q - 4'd1;
      if (do_update) begin
        CMPO <= raw ^ cmpSwapInput;
        if (cmpCount != 4'hF) cmpCount <= cmpCount + 4'd1;
      end
      if (set_err) phaseErr <= 1'b1;
      if (set_busy)      busy <= 1'b1;
      else if (clr_busy) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bg_afe_model.sv
// Directed bench for bg_afe_model: compare vectors from a table, plus hand-written
// phase sequences for SAR runs, protocol errors, restart, power-down and reset.
`timescale 1ns/1ps
module tb_bg_afe_model;

  logic       clk = 1'b0;
  logic       reset_n, pwrup;
  logic [7:0] idacCoarse, diodeSelect, cfgTarget;
  logic       resPtatEnable_n, cmpZeroOffset, cmpSwapInput;
  logic [1:0] c1, c2;
  logic [3:0] cfgOffset;
  logic       cmpo, phase_err, busy;
  logic [3:0] cmp_count;
  logic       cmpo4, phase_err4, busy4;
  logic [3:0] cmp_count4;
  int         checks = 0;
  int         errors = 0;

  always #50 clk = ~clk;

  bg_afe_model #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .pwrup(pwrup), .idacCoarse(idacCoarse),
    .diodeSelect(diodeSelect), .resPtatEnable_n(resPtatEnable_n), .c1(c1), .c2(c2),
    .cmpZeroOffset(cmpZeroOffset), .cmpSwapInput(cmpSwapInput), .cfgTarget(cfgTarget),
    .cfgOffset(cfgOffset), .CMPO(cmpo), .cmpCount(cmp_count), .phaseErr(phase_err), .busy(busy)
  );

  bg_afe_model #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .pwrup(pwrup), .idacCoarse(idacCoarse),
    .diodeSelect(diodeSelect), .resPtatEnable_n(resPtatEnable_n), .c1(c1), .c2(c2),
    .cmpZeroOffset(cmpZeroOffset), .cmpSwapInput(cmpSwapInput), .cfgTarget(cfgTarget),
    .cfgOffset(cfgOffset), .CMPO(cmpo4), .cmpCount(cmp_count4), .phaseErr(phase_err4), .busy(busy4)
  );

  typedef struct {
    logic [7:0] cs, cb, tgt;
    logic [3:0] ofs;
    logic       zero, swap, exp_cmpo;
    logic [3:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    diodeSelect = 8'h00; resPtatEnable_n = 1'b1; c1 = 2'd0; c2 = 2'd0;
  endtask

  task automatic set_cfg(input logic [7:0] tgt, input logic [3:0] ofs, input logic zero, input logic swap);
    cfgTarget = tgt; cfgOffset = ofs; cmpZeroOffset = zero; cmpSwapInput = swap;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pwrup = 1'b1; idle_in();
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic to_settle(input logic [7:0] cs, input logic [7:0] cb);
    diodeSelect = 8'h01; resPtatEnable_n = 1'b1; c1 = 2'd2; c2 = 2'd0; idacCoarse = cs; step();
    c1 = 2'd0; step();
    diodeSelect = 8'hFF; resPtatEnable_n = 1'b0; c2 = 2'd2; idacCoarse = cb; step();
    c2 = 2'd0; step();
    c1 = 2'd1; c2 = 2'd1; step();
  endtask

  task automatic do_compare(input logic [7:0] cs, input logic [7:0] cb, input int wait_n);
    to_settle(cs, cb);
    repeat (wait_n) step();
    idle_in(); step();
  endtask

  // Plays the SAR controller: keep a trial bit unless CMPO says the code is above balance.
  task automatic sar_run(output logic [7:0] res);
    logic [7:0] code, trial;
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial = code | (8'h01 << b);
      do_compare(trial, trial, 1);
      if (cmpo == 1'b0) code = trial;
    end
    res = code;
  endtask

  initial begin
    logic [7:0] sar_res;
    vecs[0] = '{8'h80, 8'h80, 8'h80, 4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[1] = '{8'h80, 8'h80, 8'h80, 4'h1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h80, 4'h1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h80, 4'h1, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h80, 4'h1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 4'h7, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0};
    vecs[6] = '{8'h81, 8'h81, 8'h80, 4'hF, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 8'hFF, 4'h8, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0};
    vecs[8] = '{8'h40, 8'h41, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1};
    vecs[9] = '{8'h5A, 8'h5A, 8'h5A, 4'h0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1};

    idacCoarse = 8'h00;
    set_cfg(8'h5A, 4'h0, 1'b0, 1'b0);
    do_reset();
    chk("reset cmpo", int'(cmpo), 0);
    chk("reset count", int'(cmp_count), 0);
    chk("reset err", int'(phase_err), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset count s4", int'(cmp_count4), 0);

    sar_run(sar_res);
    chk("sar converge", int'(sar_res), 'h5A);
    chk("sar count", int'(cmp_count), 8);
    chk("sar err", int'(phase_err), 0);

    set_cfg(8'h5A, 4'h0, 1'b0, 1'b1);
    sar_run(sar_res);
    chk("sar swap path", int'(sar_res), 'hFF);
    chk("count saturate", int'(cmp_count), 15);
    chk("sar swap err", int'(phase_err), 0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_cfg(vecs[i].tgt, vecs[i].ofs, vecs[i].zero, vecs[i].swap);
      do_compare(vecs[i].cs, vecs[i].cb, 1);
      chk($sformatf("vec%0d cmpo", i), int'(cmpo), int'(vecs[i].exp_cmpo));
      chk($sformatf("vec%0d count", i), int'(cmp_count), int'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d err", i), int'(phase_err), int'(vecs[i].exp_err));
      chk($sformatf("vec%0d busy", i), int'(busy), 0);
    end

    do_reset();
    set_cfg(8'h7F, 4'h0, 1'b0, 1'b0);
    do_compare(8'h80, 8'h80, 1);
    chk("pre cmp_idle cmpo", int'(cmpo), 1);
    c1 = 2'd1; c2 = 2'd1; step();
    chk("cmp_idle err", int'(phase_err), 1);
    chk("cmp_idle cmpo hold", int'(cmpo), 1);
    chk("cmp_idle count hold", int'(cmp_count), 1);
    idle_in(); step();

    do_reset();
    diodeSelect = 8'hFF; resPtatEnable_n = 1'b1; c1 = 2'd2; c2 = 2'd2; step();
    chk("startup ignored err", int'(phase_err), 0);
    chk("startup ignored busy", int'(busy), 0);
    idle_in(); step();
    diodeSelect = 8'hFF; resPtatEnable_n = 1'b0; c2 = 2'd2; step();
    chk("big_idle err", int'(phase_err), 1);
    idle_in(); step();

    do_reset();
    set_cfg(8'h20, 4'h0, 1'b0, 1'b0);
    diodeSelect = 8'h01; resPtatEnable_n = 1'b1; c1 = 2'd2; idacCoarse = 8'h10; step();
    chk("small busy", int'(busy), 1);
    c1 = 2'd0; step();
    c1 = 2'd2; idacCoarse = 8'h33; step();
    c1 = 2'd0; step();
    diodeSelect = 8'hFF; resPtatEnable_n = 1'b0; c2 = 2'd2; step();
    c2 = 2'd0; step();
    c1 = 2'd1; c2 = 2'd1; step();
    step();
    chk("restart cmpo", int'(cmpo), 1);
    chk("restart err", int'(phase_err), 0);
    chk("restart count", int'(cmp_count), 1);
    chk("restart busy", int'(busy), 0);
    idle_in(); step();

    do_reset();
    set_cfg(8'h00, 4'h0, 1'b0, 1'b0);
    to_settle(8'h80, 8'h80);
    repeat (3) step();
    chk("s4 latency cmpo", int'(cmpo4), 0);
    chk("s4 latency busy", int'(busy4), 1);
    step();
    chk("s4 cmpo", int'(cmpo4), 1);
    chk("s4 count", int'(cmp_count4), 1);
    chk("s4 busy done", int'(busy4), 0);
    idle_in(); step();
    c1 = 2'd1; c2 = 2'd1; step();
    chk("s4 err", int'(phase_err4), 1);
    idle_in(); step();
    to_settle(8'h80, 8'h80);
    step();
    chk("s4 settle busy", int'(busy4), 1);
    idle_in(); pwrup = 1'b0; step();
    chk("pwrdn cmpo", int'(cmpo4), 0);
    chk("pwrdn busy", int'(busy4), 0);
    chk("pwrdn count hold", int'(cmp_count4), 1);
    chk("pwrdn err hold", int'(phase_err4), 1);
    pwrup = 1'b1;
    repeat (6) step();
    chk("pwrdn no late cmpo", int'(cmpo4), 0);
    chk("pwrdn no late count", int'(cmp_count4), 1);
    to_settle(8'h80, 8'h80);
    step();
    reset_n = 1'b0; step();
    chk("midrst count", int'(cmp_count4), 0);
    chk("midrst err", int'(phase_err4), 0);
    chk("midrst busy", int'(busy4), 0);
    reset_n = 1'b1; idle_in();
    repeat (6) step();
    chk("midrst discard cmpo", int'(cmpo4), 0);
    chk("midrst discard count", int'(cmp_count4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
